// File: rtl/dpa_alu_issue_ctl_if.sv
// dpa_alu_issue_ctl_if: request, ALU-control and response channels of the ALU issue stage.
interface dpa_alu_issue_ctl_if #(parameter int WIDTH = 8);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             alu_enable;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_timeout;
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_ready, alu_result, alu_carry, rsp_ready,
        output req_ready, alu_enable, alu_sel, alu_a, alu_b, rsp_valid, rsp_result, rsp_carry, rsp_timeout
    );
    modport master (
        output req_valid, req_op, req_a, req_b, alu_ready, alu_result, alu_carry, rsp_ready,
        input  req_ready, alu_enable, alu_sel, alu_a, alu_b, rsp_valid, rsp_result, rsp_carry, rsp_timeout
    );
endinterface

// File: rtl/dpa_alu_issue_ctl.sv
// dpa_alu_issue_ctl: issues one ALU op, waits for ready or timeout, returns the result; DPA_ALU_ISSUE_RANDOM_DELAY_EN adds an LFSR-driven pre-RUN delay.
module dpa_alu_issue_ctl #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic                clock,
    input logic                reset,
    dpa_alu_issue_ctl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state_q, state_d, op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d, alu_enable_q, alu_enable_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_timeout_q, rsp_timeout_d;
    logic             accept, done, expire, run, run_go;
    logic [1:0]       first_state;

    assign accept = state_q == IDLE && bus.req_valid && req_ready_q;
    assign done   = state_q == RUN && bus.alu_ready;
    assign expire = state_q == RUN && !bus.alu_ready && cnt_q == 8'(TIMEOUT_CYCLES);

`ifdef DPA_ALU_ISSUE_RANDOM_DELAY_EN
    localparam logic [1:0] DELAY = 2'd1;
    logic [7:0] lfsr_q, lfsr_d;
    logic [1:0] dly_q, dly_d;
    always_comb begin
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        dly_d       = accept ? lfsr_q[1:0] : state_q == DELAY ? dly_q - 2'd1 : dly_q;
        first_state = lfsr_q[1:0] == 2'd0 ? RUN : DELAY;
        run_go      = state_q == DELAY && dly_q == 2'd1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
            dly_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            dly_q  <= dly_d;
        end
    end
`else
    assign first_state = RUN;
    assign run_go      = 1'b0;
`endif

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        state_d       = accept ? first_state : (done || expire) ? RESP :
                        (state_q == RESP && bus.rsp_ready) ? IDLE : run_go ? RUN : state_q;
        op_d          = accept ? bus.req_op : op_q;
        a_d           = accept ? bus.req_a : a_q;
        b_d           = accept ? bus.req_b : b_q;
        cnt_d         = state_q == RUN ? cnt_q + 8'd1 : 8'd0;
        run           = state_d == RUN;
        req_ready_d   = state_d == IDLE;
        alu_enable_d  = run;
        alu_sel_d     = run ? op_d : 2'd0;
        alu_a_d       = run ? a_d : '0;
        alu_b_d       = run ? b_d : '0;
        rsp_valid_d   = state_d == RESP;
        rsp_result_d  = done ? bus.alu_result : expire ? '0 : rsp_result_q;
        rsp_carry_d   = done ? (op_q == 2'b00 && bus.alu_carry) : expire ? 1'b0 : rsp_carry_q;
        rsp_timeout_d = done ? 1'b0 : expire ? 1'b1 : rsp_timeout_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            alu_enable_q  <= 1'b0;
            alu_sel_q     <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            alu_enable_q  <= alu_enable_d;
            alu_sel_q     <= alu_sel_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.alu_enable  = alu_enable_q;
    assign bus.alu_sel     = alu_sel_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_dpa_alu_issue_ctl.sv
// tb_dpa_alu_issue_ctl: scoreboard bench with a behavioural ALU control that raises ready after K enabled edges.
module tb_dpa_alu_issue_ctl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dpa_alu_issue_ctl_if #(.WIDTH(8)) bus ();
    dpa_alu_issue_ctl #(.WIDTH(8), .TIMEOUT_CYCLES(15)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] res;
        logic       cy;
        logic       to;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int alu_k = 1;
    int acnt = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [1:0] acc_d = 2'd0;
    logic [1:0] cur_op = 2'd0;
    logic [7:0] cur_a = 8'd0, cur_b = 8'd0;
    logic [8:0] sum;
    logic prev_en = 1'b0, prev_v = 1'b0;

    always @(posedge clock) begin
        if (!bus.alu_enable) begin
            acnt          <= 0;
            bus.alu_ready <= 1'b0;
        end else begin
            acnt          <= acnt + 1;
            bus.alu_ready <= alu_k != 0 && acnt + 1 >= alu_k;
        end
    end

    // Carry is produced for every op so masking of non-ADD carries is visible.
    always_comb begin
        sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = bus.alu_sel == 2'd0 ? sum[7:0] : bus.alu_sel == 2'd1 ? (bus.alu_a | bus.alu_b) :
                         bus.alu_sel == 2'd2 ? (bus.alu_a ^ bus.alu_b) : (bus.alu_a & bus.alu_b);
        bus.alu_carry  = sum[8];
    end

`ifdef DPA_ALU_ISSUE_RANDOM_DELAY_EN
    logic [7:0] ref_lfsr;
    always @(posedge clock or posedge reset) begin
        if (reset) ref_lfsr <= 8'hA5;
        else ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
`endif

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && bus.req_valid && bus.req_ready) begin
            acc_cyc <= cyc + 1;
`ifdef DPA_ALU_ISSUE_RANDOM_DELAY_EN
            acc_d <= ref_lfsr[1:0];
`else
            acc_d <= 2'd0;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_alu_enable"}, bus.alu_enable, 0);
        check({tag, "_alu_ops"}, {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_fields"}, {bus.rsp_result, bus.rsp_carry, bus.rsp_timeout}, 0);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int k,
                        input logic [7:0] er, input logic ec, input logic et, input int lat, input bit push);
        int i = 0;
        alu_k  = k;
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
        if (push) sbq.push_back('{er, ec, et, lat});
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && i < 200) begin
            @(negedge clock);
            i++;
        end
        check("req_accept_seen", bus.req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        int i = 0;
        while (!(bus.rsp_valid && bus.rsp_ready) && i < 400) begin
            @(negedge clock);
            i++;
        end
        check("rsp_handshake_seen", bus.rsp_valid && bus.rsp_ready, 1);
        @(negedge clock);
        check("req_ready_after_rsp", {bus.req_ready, bus.rsp_valid}, 2'b10);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_en = 1'b0;
                prev_v  = 1'b0;
            end else begin
                if (bus.alu_enable && !prev_en) check("enable_gap", cyc - acc_cyc, 32'(acc_d));
                if (bus.alu_enable) check("alu_operands", {bus.alu_sel, bus.alu_a, bus.alu_b}, {cur_op, cur_a, cur_b});
                else check("alu_idle_zero", {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
                if (bus.rsp_valid && !prev_v) begin
                    check("rsp_enable_low", bus.alu_enable, 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got result %0h with empty scoreboard", bus.rsp_result);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_result", bus.rsp_result, e.res);
                        check("rsp_carry", bus.rsp_carry, e.cy);
                        check("rsp_timeout", bus.rsp_timeout, e.to);
                        check("rsp_latency", cyc - acc_cyc, e.lat + int'(acc_d));
                    end
                end
                prev_en = bus.alu_enable;
                prev_v  = bus.rsp_valid;
            end
        end
    end

    logic [1:0] t_op [8] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3};
    logic [7:0] t_a  [8] = '{8'h3C, 8'hF0, 8'hA0, 8'hF3, 8'h7F, 8'hFF, 8'hFF, 8'h0F};
    logic [7:0] t_b  [8] = '{8'h0F, 8'h20, 8'h05, 8'h3C, 8'h01, 8'hFF, 8'h55, 8'hF0};
    int         t_k  [8] = '{1, 4, 2, 3, 2, 1, 1, 2};
    logic [7:0] t_r  [8] = '{8'h33, 8'h10, 8'hA5, 8'h30, 8'h80, 8'hFE, 8'hAA, 8'h00};
    logic       t_c  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int i;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = 8'd0;
        bus.req_b     = 8'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        check("req_ready_at_release", bus.req_ready, 0);
        @(negedge clock);
        check("req_ready_after_release", bus.req_ready, 1);

        for (int n = 0; n < 8; n++) begin
            send(t_op[n], t_a[n], t_b[n], t_k[n], t_r[n], t_c[n], 1'b0, t_k[n] + 1, 1'b1);
            finish_rsp();
        end

        send(2'd0, 8'h12, 8'h34, 0, 8'h00, 1'b0, 1'b1, 16, 1'b1);
        finish_rsp();

        bus.rsp_ready = 1'b0;
        send(2'd1, 8'h12, 8'h34, 2, 8'h36, 1'b0, 1'b0, 3, 1'b1);
        i = 0;
        while (!bus.rsp_valid && i < 100) begin
            @(negedge clock);
            i++;
        end
        bus.req_op    = 2'd2;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("hold_rsp", {bus.rsp_valid, bus.rsp_result, bus.req_ready}, {1'b1, 8'h36, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        send(2'd2, 8'h12, 8'h34, 1, 8'h26, 1'b0, 1'b0, 2, 1'b1);
        finish_rsp();

        send(2'd0, 8'h01, 8'h02, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        i = 0;
        while (!bus.alu_enable && i < 20) begin
            @(negedge clock);
            i++;
        end
        repeat (2) @(negedge clock);
        check("mid_run_enable", bus.alu_enable, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        check("req_ready_mid_release", bus.req_ready, 0);
        @(negedge clock);
        check("req_ready_after_mid", {bus.req_ready, bus.rsp_valid}, 2'b10);
        send(2'd2, 8'h3C, 8'h0F, 1, 8'h33, 1'b0, 1'b0, 2, 1'b1);
        finish_rsp();

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end
endmodule
